// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard frame receiver with E0/F0 prefix resolution.
// Outputs one key_valid pulse per key event, with make/break and extended flags.
module ps2_scancode_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       n_reset,
  input  logic       ps2Clk,
  input  logic       ps2Data,
  output logic [7:0] scancode,
  output logic       key_valid,
  output logic       key_release,
  output logic       key_extended,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy
);

  // state  | meaning
  // IDLE   | waiting for a start bit on the filtered falling edge
  // DATA   | shifting in 8 data bits, LSB first
  // PARITY | capturing the odd-parity bit
  // STOP   | checking the stop bit and parity, then handling the byte
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [FW-1:0] FLT_LAST = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TMR_TC   = TW'(1);

  localparam logic [7:0] BYTE_EXT = 8'hE0;
  localparam logic [7:0] BYTE_REL = 8'hF0;

  logic          clk_s1, clk_s2;
  logic          dat_s1, dat_s2;
  logic          filt;
  logic [FW-1:0] flt_cnt;
  logic          fe;

  state_t        state;
  logic [7:0]    shreg;
  logic [2:0]    bit_cnt;
  logic          par_bit;
  logic [TW-1:0] tmr;
  logic          ext_pending;
  logic          rel_pending;

  // Synchronisers reset to the idle-high line level so reset release looks quiet.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= ps2Clk;
      clk_s2 <= clk_s1;
      dat_s1 <= ps2Data;
      dat_s2 <= dat_s1;
    end
  end

  // The filtered clock flips only after FILTER_LEN consecutive disagreeing samples.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      filt    <= 1'b1;
      flt_cnt <= '0;
      fe      <= 1'b0;
    end else begin
      fe <= 1'b0;
      if (clk_s2 == filt) begin
        flt_cnt <= '0;
      end else if (flt_cnt == FLT_LAST) begin
        filt    <= clk_s2;
        flt_cnt <= '0;
        fe      <= filt;
      end else begin
        flt_cnt <= flt_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state        <= IDLE;
      shreg        <= '0;
      bit_cnt      <= '0;
      par_bit      <= 1'b0;
      tmr          <= '0;
      ext_pending  <= 1'b0;
      rel_pending  <= 1'b0;
      scancode     <= '0;
      key_valid    <= 1'b0;
      key_release  <= 1'b0;
      key_extended <= 1'b0;
      parity_err   <= 1'b0;
      frame_err    <= 1'b0;
      busy         <= 1'b0;
    end else begin
      key_valid  <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;

      if (fe) begin
        tmr <= TMR_LOAD;
        case (state)
          IDLE: begin
            if (!dat_s2) begin
              state   <= DATA;
              bit_cnt <= '0;
              busy    <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end

          DATA: begin
            shreg   <= {dat_s2, shreg[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) state <= PARITY;
          end

          PARITY: begin
            par_bit <= dat_s2;
            state   <= STOP;
          end

          STOP: begin
            state <= IDLE;
            busy  <= 1'b0;
            if (!dat_s2) begin
              frame_err <= 1'b1;
            end else if (!(^{shreg, par_bit})) begin
              // A corrupted byte may have been a prefix, so drop any pending context.
              parity_err  <= 1'b1;
              ext_pending <= 1'b0;
              rel_pending <= 1'b0;
            end else if (shreg == BYTE_EXT) begin
              ext_pending <= 1'b1;
            end else if (shreg == BYTE_REL) begin
              rel_pending <= 1'b1;
            end else begin
              scancode     <= shreg;
              key_extended <= ext_pending;
              key_release  <= rel_pending;
              key_valid    <= 1'b1;
              ext_pending  <= 1'b0;
              rel_pending  <= 1'b0;
            end
          end

          default: state <= IDLE;
        endcase
      end else if (state != IDLE) begin
        // Timeout keeps the prefix flags: only the partial byte is lost.
        if (tmr == TMR_TC) begin
          frame_err <= 1'b1;
          state     <= IDLE;
          busy      <= 1'b0;
          shreg     <= '0;
        end else begin
          tmr <= tmr - 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Directed bench for ps2_scancode_rx: PS/2 frames in, scoreboard of expected pulses.
module tb_ps2_scancode_rx;

  localparam int FLT  = 8;
  localparam int TOUT = 2000;
  localparam int H    = 20;
  // Drive-to-strobe delay: 2 synchroniser stages plus FILTER_LEN filter samples.
  localparam int FE_LAT = 2 + FLT;

  localparam int EV_KEY = 0;
  localparam int EV_PAR = 1;
  localparam int EV_FRM = 2;

  typedef struct {
    int         kind;
    logic [7:0] code;
    logic       rel;
    logic       ext;
  } ev_t;

  logic       clk = 1'b0;
  logic       n_reset;
  logic       ps2Clk;
  logic       ps2Data;
  logic [7:0] scancode;
  logic       key_valid, key_release, key_extended;
  logic       parity_err, frame_err, busy;

  int  vectors = 0;
  int  miscompares = 0;
  ev_t exp_q[$];
  ev_t mon_ev;
  int  kind_obs;

  ps2_scancode_rx #(.FILTER_LEN(FLT), .TIMEOUT_CYCLES(TOUT)) dut (
    .clk          (clk),
    .n_reset      (n_reset),
    .ps2Clk       (ps2Clk),
    .ps2Data      (ps2Data),
    .scancode     (scancode),
    .key_valid    (key_valid),
    .key_release  (key_release),
    .key_extended (key_extended),
    .parity_err   (parity_err),
    .frame_err    (frame_err),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_ev(input int kind, input logic [7:0] code, input logic rel, input logic ext);
    ev_t e;
    e.kind = kind;
    e.code = code;
    e.rel  = rel;
    e.ext  = ext;
    exp_q.push_back(e);
  endtask

  task automatic ps2_bit(input logic d);
    @(posedge clk); #1 ps2Data = d;
    repeat (H) @(posedge clk);
    #1 ps2Clk = 1'b0;
    repeat (H) @(posedge clk);
    #1 ps2Clk = 1'b1;
  endtask

  task automatic glitch(input int n);
    repeat (5) @(posedge clk);
    #1 ps2Clk = 1'b0;
    repeat (n) @(posedge clk);
    #1 ps2Clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic stop_b,
                            input int glitch_after);
    ps2_bit(1'b0);
    check("busy_in_frame", busy, 1);
    for (int i = 0; i < 8; i++) begin
      ps2_bit(b[i]);
      if (i == glitch_after) glitch(5);
    end
    ps2_bit((~^b) ^ bad_par);
    ps2_bit(stop_b);
    repeat (30) @(posedge clk);
    @(negedge clk);
    check("busy_idle", busy, 0);
  endtask

  always @(negedge clk) begin
    if (n_reset && (key_valid || parity_err || frame_err)) begin
      check("pulse_onehot", $countones({key_valid, parity_err, frame_err}), 1);
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", {29'd0, key_valid, parity_err, frame_err}, 0);
      end else begin
        mon_ev   = exp_q.pop_front();
        kind_obs = key_valid ? EV_KEY : (parity_err ? EV_PAR : EV_FRM);
        check("event_kind", kind_obs, mon_ev.kind);
        if (mon_ev.kind == EV_KEY) begin
          check("scancode", scancode, mon_ev.code);
          check("key_release", key_release, mon_ev.rel);
          check("key_extended", key_extended, mon_ev.ext);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired observed=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int  cnt;
    bit  found;
    logic [7:0] pb;

    n_reset = 1'b0;
    ps2Clk  = 1'b1;
    ps2Data = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_scancode", scancode, 0);
    check("rst_pulses", {key_valid, parity_err, frame_err}, 0);
    check("rst_flags", {key_release, key_extended}, 0);
    check("rst_busy", busy, 0);
    @(posedge clk); #1 n_reset = 1'b1;
    repeat (20) @(posedge clk);

    // plain make code
    expect_ev(EV_KEY, 8'h1C, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b1, -1);

    // break
    expect_ev(EV_KEY, 8'h1C, 1'b1, 1'b0);
    send_frame(8'hF0, 1'b0, 1'b1, -1);
    send_frame(8'h1C, 1'b0, 1'b1, -1);

    // extended break, with a repeated E0
    expect_ev(EV_KEY, 8'h75, 1'b1, 1'b1);
    send_frame(8'hE0, 1'b0, 1'b1, -1);
    send_frame(8'hE0, 1'b0, 1'b1, -1);
    send_frame(8'hF0, 1'b0, 1'b1, -1);
    send_frame(8'h75, 1'b0, 1'b1, -1);

    // parity error clears pending E0
    expect_ev(EV_PAR, 8'h00, 1'b0, 1'b0);
    expect_ev(EV_KEY, 8'h1C, 1'b0, 1'b0);
    send_frame(8'hE0, 1'b0, 1'b1, -1);
    send_frame(8'h1C, 1'b1, 1'b1, -1);
    send_frame(8'h1C, 1'b0, 1'b1, -1);

    // glitches while idle and mid-frame
    glitch(3);
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("busy_after_idle_glitch", busy, 0);
    expect_ev(EV_KEY, 8'h29, 1'b0, 1'b0);
    send_frame(8'h29, 1'b0, 1'b1, 3);

    // bad stop bit, then a spurious fall with data high while idle
    expect_ev(EV_FRM, 8'h00, 1'b0, 1'b0);
    send_frame(8'h33, 1'b0, 1'b0, -1);
    expect_ev(EV_FRM, 8'h00, 1'b0, 1'b0);
    ps2_bit(1'b1);
    repeat (30) @(posedge clk);

    // timeout after 4 data bits; pending F0 survives it
    send_frame(8'hF0, 1'b0, 1'b1, -1);
    expect_ev(EV_FRM, 8'h00, 1'b0, 1'b0);
    pb = 8'h5A;
    ps2_bit(1'b0);
    for (int i = 0; i < 3; i++) ps2_bit(pb[i]);
    @(posedge clk); #1 ps2Data = pb[3];
    repeat (H) @(posedge clk);
    #1 ps2Clk = 1'b0;
    cnt   = 0;
    found = 1'b0;
    while (!found && cnt < TOUT + 200) begin
      @(posedge clk);
      cnt++;
      @(negedge clk);
      if (frame_err) found = 1'b1;
    end
    check("timeout_seen", found, 1);
    check("timeout_latency", cnt, FE_LAT + TOUT);
    check("timeout_busy", busy, 0);
    @(posedge clk); #1 ps2Clk = 1'b1;
    repeat (30) @(posedge clk);
    expect_ev(EV_KEY, 8'h5A, 1'b1, 1'b0);
    send_frame(8'h5A, 1'b0, 1'b1, -1);

    // async reset mid-DATA after F0
    send_frame(8'hF0, 1'b0, 1'b1, -1);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    @(negedge clk);
    check("busy_before_reset", busy, 1);
    #2 n_reset = 1'b0;
    #1;
    check("mid_rst_scancode", scancode, 0);
    check("mid_rst_pulses", {key_valid, parity_err, frame_err}, 0);
    check("mid_rst_flags", {key_release, key_extended}, 0);
    check("mid_rst_busy", busy, 0);
    ps2Data = 1'b1;
    repeat (5) @(posedge clk);
    #1 n_reset = 1'b1;
    repeat (30) @(posedge clk);
    expect_ev(EV_KEY, 8'h1C, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b1, -1);

    repeat (50) @(posedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
